// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the instruction fetch unit and its buffer.
// Latency: none, declarations only.
// Backpressure: not applicable.
package cpu_pkg;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } ifu_state_e;

   // Force a fetch target onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous buffer of fetched {instr, pc} entries with a flush input.
// Latency: a pushed entry is visible on head_dat the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens the same cycle; flush beats push and pop.
module fetch_fifo #(
   parameter int           DEPTH   = 4,
   parameter int           W       = 64,
   parameter logic [W-1:0] RST_DAT = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic [W-1:0]           push_dat,
   input  logic                   pop,
   output logic [W-1:0]           head_dat,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_en, pop_en;

   assign full     = (count_q == (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign head_dat = mem_q[rd_ptr_q];
   assign pop_en   = pop && !empty;
   assign push_en  = push && (!full || pop_en);

   // Next storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_en) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
      end
   end

   // Storage is reset too so the head shows RST_DAT straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= RST_DAT;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: issues in-order word fetches, buffers responses, hands {Instr, instr_pc} to the datapath.
// Latency: instr_valid rises the cycle after the imem_rsp_valid that carries the word.
// Backpressure: requests stop once buffered + outstanding reaches FIFO_DEPTH; instr_ready pops the head.
// Optional: IFU_MISALIGN_CHECK_EN turns a misaligned redirect into a sticky fault and HALT.
import cpu_pkg::*;

module instr_fetch_unit #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        Reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] Instr,
   output logic [31:0] instr_pc,
   output logic        fetch_fault
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   // Stale responses still owed by memory; wide enough for many back-to-back redirects.
   localparam int DW = 8;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   ifu_state_e    state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [DW-1:0] discard_q, discard_d;

   logic [63:0]   f_head;
   logic [CW-1:0] f_count;
   logic          f_full, f_empty, f_push, f_pop;
   logic [CW:0]   in_flight;
   logic          redir_en, req_acc, rsp_take;

   assign in_flight = {1'b0, f_count} + {1'b0, outstanding_q};
   assign redir_en  = redirect && (state_q != ST_HALT);
   assign imem_req_valid = (state_q == ST_RUN) && !redirect && !f_full && (in_flight < DEPTH_C);
   assign imem_req_addr  = fetch_pc_q;
   assign req_acc  = imem_req_valid && imem_req_ready;
   // A response with nothing owed is ignored; BOOT never has anything owed but is excluded explicitly.
   assign rsp_take = imem_rsp_valid && (state_q != ST_BOOT) && ((outstanding_q != '0) || (discard_q != '0));
   assign f_push   = rsp_take && (discard_q == '0) && !redir_en;
   assign f_pop    = instr_valid && instr_ready && !redir_en;

   assign instr_valid = !f_empty && (state_q == ST_RUN);
   assign Instr       = f_head[63:32];
   assign instr_pc    = f_head[31:0];

`ifdef IFU_MISALIGN_CHECK_EN
   logic fault_q, fault_d;
   assign fetch_fault = fault_q;
`else
   assign fetch_fault = 1'b0;
`endif

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .W       (64),
      .RST_DAT ({NOP_INSTR, 32'h0000_0000})
   ) u_fifo (
      .clk      (clk),
      .rst_n    (Reset),
      .flush    (redir_en),
      .push     (f_push),
      .push_dat ({imem_rsp_data, rsp_pc_q}),
      .pop      (f_pop),
      .head_dat (f_head),
      .full     (f_full),
      .empty    (f_empty),
      .count    (f_count)
   );

   // Next state: redirect overrides acceptance/push/pop; owed responses become discards.
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
`ifdef IFU_MISALIGN_CHECK_EN
      fault_d       = fault_q;
`endif
      if (state_q == ST_BOOT) begin
         state_d = ST_RUN;
      end
      if (redir_en) begin
         fetch_pc_d    = word_align(redirect_pc);
         rsp_pc_d      = word_align(redirect_pc);
         outstanding_d = '0;
         // A response landing in the redirect cycle is one of the owed words and is dropped here.
         discard_d     = discard_q + DW'(outstanding_q) - DW'(rsp_take);
`ifdef IFU_MISALIGN_CHECK_EN
         if (redirect_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
         end
`endif
      end else begin
         if (req_acc) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (rsp_take) begin
            if (discard_q != '0) begin
               discard_d = discard_q - DW'(1);
            end else begin
               rsp_pc_d = rsp_pc_q + 32'd4;
            end
         end
         outstanding_d = outstanding_q + CW'(req_acc) - CW'(f_push);
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q       <= ST_BOOT;
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
         fault_q       <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
`ifdef IFU_MISALIGN_CHECK_EN
         fault_q       <= fault_d;
`endif
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench with an in-order memory model and a scoreboard of {instr, pc}.
// Latency: memory answers the cycle after acceptance unless held.
// Backpressure: instr_ready and imem_req_ready are driven per directed step.
module tb_instr_fetch_unit;

   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk;
   logic        Reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] Instr;
   logic [31:0] instr_pc;
   logic        fetch_fault;

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [63:0] expq [$];
   logic [31:0] pend_q [$];
   logic [31:0] exp_addr;
   logic [31:0] stall_addr;
   bit          stall_prev;
   bit          mem_hold;
   int          acc_cnt;

   instr_fetch_unit #(
      .FIFO_DEPTH (DEPTH),
      .RESET_PC   (RST_PC)
   ) dut (
      .clk            (clk),
      .Reset          (Reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .Instr          (Instr),
      .instr_pc       (instr_pc),
      .fetch_fault    (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'd3) + 32'h1234_5678;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs are already set; sample before the edge, update memory after it.
   task automatic tick();
      logic        acc;
      logic [31:0] a;
      logic [63:0] e;
      #2;
      if (stall_prev && imem_req_valid) chk("req_addr_hold", imem_req_addr, stall_addr);
      acc = imem_req_valid && imem_req_ready;
      a   = imem_req_addr;
      if (redirect) begin
         chk("redirect_no_req", 32'(imem_req_valid), 32'd0);
         expq.delete();
         exp_addr = redirect_pc & 32'hFFFF_FFFC;
      end else if (instr_valid && instr_ready) begin
         if (expq.size() == 0) begin
            chk("spurious_instr_pc", instr_pc, 32'hFFFF_FFFF);
         end else begin
            e = expq.pop_front();
            chk("instr", Instr, e[63:32]);
            chk("instr_pc", instr_pc, e[31:0]);
         end
      end
      if (acc) begin
         chk("req_addr", a, exp_addr);
         exp_addr = exp_addr + 32'd4;
         acc_cnt++;
      end
      stall_prev = imem_req_valid && !imem_req_ready;
      stall_addr = imem_req_addr;
      @(posedge clk);
      #1;
      if (acc) begin
         pend_q.push_back(a);
         expq.push_back({word_of(a), a});
      end
      if (!mem_hold && pend_q.size() != 0) begin
         a = pend_q.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = word_of(a);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
   endtask

   // Assert reset asynchronously, check reset values, and show junk responses are ignored.
   task automatic reset_boot();
      Reset          = 1'b0;
      redirect       = 1'b0;
      imem_req_ready = 1'b0;
      instr_ready    = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", Instr, 32'h0000_0013);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_fault", 32'(fetch_fault), 32'd0);
      chk("rst_req_addr", imem_req_addr, RST_PC);
      @(posedge clk);
      @(posedge clk);
      #1;
      Reset = 1'b1;
      #2;
      chk("boot_req_valid", 32'(imem_req_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("run_req_valid", 32'(imem_req_valid), 32'd1);
      chk("run_req_addr", imem_req_addr, RST_PC);
      @(posedge clk);
      #1;
      chk("junk_rsp_ignored", 32'(instr_valid), 32'd0);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      pend_q.delete();
      expq.delete();
      exp_addr   = RST_PC;
      stall_prev = 1'b0;
      mem_hold   = 1'b0;
      acc_cnt    = 0;
   endtask

   task automatic drain();
      imem_req_ready = 1'b0;
      instr_ready    = 1'b1;
      for (int i = 0; i < 24 && expq.size() != 0; i++) tick();
      chk("drain_left", 32'(expq.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset          = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect       = 1'b0;
      redirect_pc    = 32'h0;
      instr_ready    = 1'b0;
      mem_hold       = 1'b0;
      stall_prev     = 1'b0;
      acc_cnt        = 0;
      exp_addr       = RST_PC;
      #3;
      reset_boot();

      // Streaming from RESET_PC with a 1-cycle memory.
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      tick();
      chk("first_latency_0", 32'(instr_valid), 32'd0);
      tick();
      chk("first_latency_1", 32'(instr_valid), 32'd1);
      chk("first_pc", instr_pc, RST_PC);
      for (int i = 0; i < 6; i++) tick();

      // Memory stalls requests, then the datapath stalls for 10 cycles.
      drain();
      imem_req_ready = 1'b1;
      instr_ready    = 1'b0;
      acc_cnt        = 0;
      for (int i = 0; i < 10; i++) tick();
      chk("stall_acc_cnt", 32'(acc_cnt), 32'(DEPTH));
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_instr_valid", 32'(instr_valid), 32'd1);
      drain();

      // Redirect with two requests outstanding.
      mem_hold       = 1'b1;
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      tick();
      tick();
      chk("held_pending", 32'(pend_q.size()), 32'd2);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      tick();
      redirect    = 1'b0;
      mem_hold    = 1'b0;
      instr_ready = 1'b0;
      for (int i = 0; i < 10 && !instr_valid; i++) tick();
      chk("redir_valid", 32'(instr_valid), 32'd1);
      chk("redir_pc", instr_pc, 32'h0000_0200);
      chk("redir_instr", Instr, word_of(32'h0000_0200));
      instr_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();

      // Redirect near the top of memory while streaming; a response lands in the redirect cycle.
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect = 1'b0;
      tick();
      tick();
      chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
      chk("wrap_req_addr", imem_req_addr, 32'h0000_0000);
      for (int i = 0; i < 6; i++) tick();

      // Misaligned redirect.
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0202;
      tick();
      redirect = 1'b0;
      acc_cnt  = 0;
`ifdef IFU_MISALIGN_CHECK_EN
      chk("mis_fault", 32'(fetch_fault), 32'd1);
      for (int i = 0; i < 5; i++) tick();
      chk("halt_no_acc", 32'(acc_cnt), 32'd0);
      chk("halt_req_valid", 32'(imem_req_valid), 32'd0);
      chk("halt_instr_valid", 32'(instr_valid), 32'd0);
      chk("halt_fault_sticky", 32'(fetch_fault), 32'd1);
`else
      chk("mis_fault", 32'(fetch_fault), 32'd0);
      chk("mis_req_addr", imem_req_addr, 32'h0000_0200);
      for (int i = 0; i < 10 && !instr_valid; i++) tick();
      chk("mis_instr_pc", instr_pc, 32'h0000_0200);
      for (int i = 0; i < 4; i++) tick();
      drain();
`endif

      // Fill the buffer, then reset mid-stream.
      reset_boot();
      imem_req_ready = 1'b1;
      instr_ready    = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("full_instr_valid", 32'(instr_valid), 32'd1);
      chk("full_req_valid", 32'(imem_req_valid), 32'd0);
      reset_boot();
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of fetched-instruction buffer entries (power of 2, range 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have ports in this order: clk in 1, rising-edge clock; Reset in 1, asynchronous active-low reset.
REQ-004 SHALL have imem_req_valid out 1, meaning a fetch request is presented.
REQ-005 SHALL have imem_req_ready in 1, meaning memory accepts the request this cycle.
REQ-006 SHALL have imem_req_addr out 32, meaning the word-aligned fetch address.
REQ-007 SHALL have imem_rsp_valid in 1, meaning one in-order response word is returned this cycle.
REQ-008 SHALL have imem_rsp_data in 32, meaning the response instruction word.
REQ-009 SHALL have redirect in 1, meaning a taken branch or jump (datapath PCSrc) in this cycle.
REQ-010 SHALL have redirect_pc in 32, meaning the new fetch target (datapath PCNext).
REQ-011 SHALL have instr_valid out 1, meaning the buffer head holds a valid instruction.
REQ-012 SHALL have instr_ready in 1, meaning the datapath consumes the head this cycle.
REQ-013 SHALL have Instr out 32, meaning the head instruction, driving datapath Instr.
REQ-014 SHALL have instr_pc out 32, meaning the address of Instr.
REQ-015 SHALL have fetch_fault out 1, sticky misaligned-redirect flag (see Configuration).

Function
REQ-016 SHALL implement FSM states BOOT, RUN and HALT; BOOT->RUN after exactly one cycle; RUN->HALT only per REQ-030; HALT exits only via reset.
REQ-017 SHALL, in RUN, assert imem_req_valid when (entries + outstanding) < FIFO_DEPTH.
REQ-018 SHALL treat a request as accepted when imem_req_valid && imem_req_ready, incrementing fetch_pc by 4 (mod 2^32, wrapping 0xFFFF_FFFC->0) and outstanding by 1.
REQ-019 SHALL hold imem_req_addr stable while imem_req_valid is high and not accepted.
REQ-020 SHALL push {rsp_data, pc} into the buffer on imem_rsp_valid unless the discard counter is non-zero, in which case it drops the word and decrements discard.
REQ-021 SHALL pop the head when instr_valid && instr_ready; push and pop in the same cycle SHALL leave the entry count unchanged, including when full.
REQ-022 SHALL present Instr, instr_pc from registered buffer storage; minimum latency from request acceptance to instr_valid is one cycle after imem_rsp_valid.
REQ-023 SHALL, on redirect, flush all entries, move outstanding into discard, set fetch_pc = {redirect_pc[31:2],2'b00}, and deassert imem_req_valid that cycle.
REQ-024 SHALL give redirect priority over a same-cycle push, pop or acceptance; a response arriving in the redirect cycle SHALL be dropped.
REQ-025 SHALL never accept a response with outstanding + discard == 0 (ignore it; no state change).

Reset
REQ-026 SHALL, while Reset is low, force state=BOOT, fetch_pc=RESET_PC, entries, outstanding and discard to 0, imem_req_valid=0, instr_valid=0, Instr=32'h0000_0013 (NOP), instr_pc=0, fetch_fault=0.
REQ-027 SHALL discard any response that arrives during reset or the BOOT cycle.

Configuration
REQ-028 SHALL honour macro IFU_MISALIGN_CHECK_EN.
REQ-029 Without it, SHALL silently clear redirect_pc[1:0], and fetch_fault SHALL be tied 0.
REQ-030 With it, a redirect where redirect_pc[1:0] != 0 SHALL set fetch_fault, flush, and enter HALT (no requests, instr_valid=0).

Structure
REQ-031 SHALL place the NOP constant, the FSM state enum and the instruction-word width in shared package cpu_pkg.
REQ-032 SHALL instantiate the buffer as sub-module fetch_fifo (synchronous, FIFO_DEPTH entries, 64-bit entries, full/empty/count outputs).

Verification
REQ-033 SHALL cover reset release with RESET_PC=0x100 and ready=1, 1-cycle memory -> requests at 0x100, 0x104, 0x108; Instr order matches and instr_pc is correct.
REQ-034 SHALL cover instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH requests are accepted, then imem_req_valid=0; no entry is lost after ready returns.
REQ-035 SHALL cover redirect to 0x200 with 2 requests outstanding -> both stale responses are dropped, and the next instr_pc is 0x200.
REQ-036 SHALL cover fetch_pc=0xFFFF_FFFC -> the next request address is 0x0000_0000.
REQ-037 SHALL cover redirect_pc=0x202 with IFU_MISALIGN_CHECK_EN defined -> fetch_fault=1, HALT, no further requests; without the macro -> fetch resumes at 0x200.
REQ-038 SHALL cover asserting Reset mid-stream with the buffer full -> all outputs reach REQ-026 values asynchronously, and pre-reset responses are ignored.
